mipi_rx_lane_pkt: RTL and testbench
===================================

// Module: mipi_rx_lane_pkt
// PURPOSE
//  Byte-level packet receiver behind the data-lane slave's deserializer (its HSRX_DATA/SYNC/ERRSYNC/NOSYNC).
//  Per HS burst: parses the 4-byte packet header (DI, WC_L, WC_H, ECC), streams the long-packet payload,
//  checks the 16-bit CRC and ECC, and flags SoT/truncation errors. Single lane, one packet per burst.
// PARAMETERS
//  SHORT_DT_MAX  6'h0F  DI[5:0] <= this value = short packet (header only, no payload/CRC)
//  CHECK_CRC     1      0: skip CRC compare, CRC_ERR held 0
//  MAX_WC        16'hFFFF  WC above this -> WC_ERR, packet dropped (go to WAIT_EOT)
// PORTS
//  HS_BYTE_CLKD  in   1   byte clock from deserializer
//  RST_N         in   1   asynchronous active-low reset
//  RX_ACTIVE     in   1   high while HS burst in progress (deserializer enabled, lane not in stop)
//  SYNC          in   1   1-cycle pulse: clean SoT; first header byte arrives next cycle
//  ERRSYNC       in   1   1-cycle pulse: SoT with 1-bit error; treated as SYNC plus SOT_ERR_CORR
//  NOSYNC        in   1   1-cycle pulse: SoT failed; burst ignored
//  HSRX_DATA     in   8   received byte, valid every cycle after SYNC/ERRSYNC while RX_ACTIVE=1
//  HDR_VALID     out  1   1-cycle pulse: HDR_DI/HDR_WC/ECC_ERR valid
//  HDR_DI        out  8   data identifier (VC[7:6], DT[5:0])
//  HDR_WC        out  16  word count (short packet: 16-bit data field)
//  ECC_ERR       out  1   header ECC mismatch (detect only, no correction); valid with HDR_VALID
//  PAY_DATA      out  8   payload byte
//  PAY_VALID     out  1   PAY_DATA valid
//  PAY_FIRST     out  1   with first payload byte
//  PAY_LAST      out  1   with byte number WC
//  PKT_DONE      out  1   1-cycle pulse: packet complete (short: with HDR_VALID; long: after CRC)
//  CRC_ERR       out  1   valid with PKT_DONE of long packet
//  SOT_ERR_CORR  out  1   1-cycle pulse on ERRSYNC
//  SOT_ERR       out  1   1-cycle pulse on NOSYNC
//  TRUNC_ERR     out  1   1-cycle pulse: RX_ACTIVE fell before packet complete
//  WC_ERR        out  1   1-cycle pulse: WC > MAX_WC
// BEHAVIOUR
//  - Reset: all outputs 0, HDR_* 0, state IDLE, byte counter 0, CRC reg 16'hFFFF.
//  - All outputs registered; every output reflects the input byte one cycle later.
//  - FSM: IDLE -> HDR on SYNC|ERRSYNC with RX_ACTIVE=1; NOSYNC in IDLE -> SOT_ERR, stay IDLE.
//    HDR: capture 4 bytes; after byte 4: HDR_VALID; short DT -> PKT_DONE same cycle, -> WAIT_EOT;
//    long, WC=0 -> CRC; long, WC>MAX_WC -> WC_ERR, -> WAIT_EOT; else -> PAYLOAD.
//    PAYLOAD: count WC bytes (16-bit down-counter), update CRC; after byte WC -> CRC.
//    CRC: capture 2 bytes (LSB first); then PKT_DONE + CRC_ERR, -> WAIT_EOT.
//    WAIT_EOT: ignore bytes (trailer) until RX_ACTIVE=0 -> IDLE.
//  - ECC: CSI-2 6-bit Hamming over {WC_H,WC_L,DI}, ECC[7:6] must be 0; ECC_ERR=1 on mismatch,
//    packet still processed using received fields.
//  - CRC: CRC-16, poly x^16+x^12+x^5+1, reflected (0x8408), init 16'hFFFF, no final XOR, over payload
//    bytes only, LSB of each byte first. WC=0: expected CRC 16'hFFFF.
//  - RX_ACTIVE=0 in HDR/PAYLOAD/CRC: TRUNC_ERR pulse, no PKT_DONE, -> IDLE; byte that cycle discarded.
//  - SYNC/ERRSYNC/NOSYNC outside IDLE: ignored (SOT_ERR_CORR/SOT_ERR still pulse).
//  - SYNC and RX_ACTIVE=0 same cycle: stay IDLE.
//  - RST_N low mid-packet: immediate return to reset values; no PKT_DONE/TRUNC_ERR issued.
// TESTING
//  1 SYNC, bytes 00 34 12 ECC(001234) -> HDR_VALID, DI=00, WC=1234, ECC_ERR=0, PKT_DONE same cycle.
//  2 SYNC, DI=2A WC=0004 good ECC, payload 01 02 03 04, CRC correct -> 4 PAY_VALID (FIRST on 01,
//    LAST on 04), PKT_DONE 1 cycle after 2nd CRC byte, CRC_ERR=0; flip one CRC bit -> CRC_ERR=1.
//  3 Long packet, ECC byte XOR 01 -> ECC_ERR=1 with HDR_VALID, payload still streamed.
//  4 DI=2A WC=0010, RX_ACTIVE drops after 5 payload bytes -> TRUNC_ERR pulse, no PKT_DONE, IDLE.
//  5 NOSYNC with RX_ACTIVE=1 -> SOT_ERR, no HDR_VALID; ERRSYNC then short pkt -> SOT_ERR_CORR+PKT_DONE.
//  6 Long WC=0000 with CRC FF FF -> PKT_DONE, CRC_ERR=0, no PAY_VALID; MAX_WC=0100, WC=0200 -> WC_ERR.

Source files
------------

// File: rtl/mipi_rx_lane_pkt.sv
// Byte-level CSI-2 packet receiver for one data lane: header parse with ECC check,
// long-packet payload streaming with CRC-16 check, and SoT / truncation / word-count error flags.
module mipi_rx_lane_pkt #(
    parameter logic [5:0]  SHORT_DT_MAX = 6'h0F,
    parameter bit          CHECK_CRC    = 1'b1,
    parameter logic [15:0] MAX_WC       = 16'hFFFF
) (
    input  logic        hs_byte_clkd,
    input  logic        rst_n,
    input  logic        rx_active,
    input  logic        sync,
    input  logic        errsync,
    input  logic        nosync,
    input  logic [7:0]  hsrx_data,
    output logic        hdr_valid,
    output logic [7:0]  hdr_di,
    output logic [15:0] hdr_wc,
    output logic        ecc_err,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_first,
    output logic        pay_last,
    output logic        pkt_done,
    output logic        crc_err,
    output logic        sot_err_corr,
    output logic        sot_err,
    output logic        trunc_err,
    output logic        wc_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_CRC      = 3'd3,
        ST_WAIT_EOT = 3'd4
    } state_t;

    // CSI-2 header ECC: six parity bits over {WC_H, WC_L, DI}
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), one byte, LSB first
    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [1:0]  idx_r, idx_s;
    logic [7:0]  di_r, di_s, wc_l_r, wc_l_s, wc_h_r, wc_h_s, crc_lo_r, crc_lo_s;
    logic [15:0] crc_r, crc_s;
    logic        hdr_valid_r, hdr_valid_s, ecc_err_r, ecc_err_s;
    logic [7:0]  hdr_di_r, hdr_di_s, pay_data_r, pay_data_s;
    logic [15:0] hdr_wc_r, hdr_wc_s;
    logic        pay_valid_r, pay_valid_s, pay_first_r, pay_first_s, pay_last_r, pay_last_s;
    logic        pkt_done_r, pkt_done_s, crc_err_r, crc_err_s;
    logic        sot_err_corr_r, sot_err_corr_s, sot_err_r, sot_err_s;
    logic        trunc_err_r, trunc_err_s, wc_err_r, wc_err_s;
    logic [15:0] wc_cat_s;
    logic [23:0] hdr_bits_s;

    assign wc_cat_s   = {wc_h_r, wc_l_r};
    assign hdr_bits_s = {wc_h_r, wc_l_r, di_r};

    // Next-state and next-output logic
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        idx_s          = idx_r;
        di_s           = di_r;
        wc_l_s         = wc_l_r;
        wc_h_s         = wc_h_r;
        crc_lo_s       = crc_lo_r;
        crc_s          = crc_r;
        hdr_di_s       = hdr_di_r;
        hdr_wc_s       = hdr_wc_r;
        pay_data_s     = pay_data_r;
        hdr_valid_s    = 1'b0;
        ecc_err_s      = 1'b0;
        pay_valid_s    = 1'b0;
        pay_first_s    = 1'b0;
        pay_last_s     = 1'b0;
        pkt_done_s     = 1'b0;
        crc_err_s      = 1'b0;
        trunc_err_s    = 1'b0;
        wc_err_s       = 1'b0;
        sot_err_corr_s = errsync;
        sot_err_s      = nosync;

        case (state_r)
            ST_IDLE: begin
                if ((sync || errsync) && rx_active) begin
                    state_s = ST_HDR;
                    idx_s   = 2'd0;
                    crc_s   = 16'hFFFF;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!rx_active) begin
                    trunc_err_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    idx_s = idx_r + 2'd1;
                    case (idx_r)
                        2'd0:    di_s   = hsrx_data;
                        2'd1:    wc_l_s = hsrx_data;
                        2'd2:    wc_h_s = hsrx_data;
                        default: begin
                            hdr_valid_s = 1'b1;
                            hdr_di_s    = di_r;
                            hdr_wc_s    = wc_cat_s;
                            ecc_err_s   = ({2'b00, ecc_calc(hdr_bits_s)} != hsrx_data);
                            idx_s       = 2'd0;
                            if (di_r[5:0] <= SHORT_DT_MAX) begin
                                pkt_done_s = 1'b1;
                                state_s    = ST_WAIT_EOT;
                            end else if (wc_cat_s == 16'd0) begin
                                state_s = ST_CRC;
                            end else if ({1'b0, wc_cat_s} > {1'b0, MAX_WC}) begin
                                wc_err_s = 1'b1;
                                state_s  = ST_WAIT_EOT;
                            end else begin
                                cnt_s   = wc_cat_s;
                                state_s = ST_PAYLOAD;
                            end
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (!rx_active) begin
                    trunc_err_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    pay_valid_s = 1'b1;
                    pay_data_s  = hsrx_data;
                    pay_first_s = (cnt_r == hdr_wc_r);
                    pay_last_s  = (cnt_r == 16'd1);
                    crc_s       = crc_upd(crc_r, hsrx_data);
                    cnt_s       = cnt_r - 16'd1;
                    if (cnt_r == 16'd1) begin
                        idx_s   = 2'd0;
                        state_s = ST_CRC;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
            end
            ST_CRC: begin
                if (!rx_active) begin
                    trunc_err_s = 1'b1;
                    state_s     = ST_IDLE;
                end else if (idx_r == 2'd0) begin
                    crc_lo_s = hsrx_data;
                    idx_s    = 2'd1;
                end else begin
                    pkt_done_s = 1'b1;
                    crc_err_s  = CHECK_CRC && ({hsrx_data, crc_lo_r} != crc_r);
                    state_s    = ST_WAIT_EOT;
                end
            end
            ST_WAIT_EOT: begin
                if (!rx_active) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_EOT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge hs_byte_clkd or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            idx_r          <= 2'd0;
            di_r           <= 8'd0;
            wc_l_r         <= 8'd0;
            wc_h_r         <= 8'd0;
            crc_lo_r       <= 8'd0;
            crc_r          <= 16'hFFFF;
            hdr_di_r       <= 8'd0;
            hdr_wc_r       <= 16'd0;
            pay_data_r     <= 8'd0;
            hdr_valid_r    <= 1'b0;
            ecc_err_r      <= 1'b0;
            pay_valid_r    <= 1'b0;
            pay_first_r    <= 1'b0;
            pay_last_r     <= 1'b0;
            pkt_done_r     <= 1'b0;
            crc_err_r      <= 1'b0;
            sot_err_corr_r <= 1'b0;
            sot_err_r      <= 1'b0;
            trunc_err_r    <= 1'b0;
            wc_err_r       <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            idx_r          <= idx_s;
            di_r           <= di_s;
            wc_l_r         <= wc_l_s;
            wc_h_r         <= wc_h_s;
            crc_lo_r       <= crc_lo_s;
            crc_r          <= crc_s;
            hdr_di_r       <= hdr_di_s;
            hdr_wc_r       <= hdr_wc_s;
            pay_data_r     <= pay_data_s;
            hdr_valid_r    <= hdr_valid_s;
            ecc_err_r      <= ecc_err_s;
            pay_valid_r    <= pay_valid_s;
            pay_first_r    <= pay_first_s;
            pay_last_r     <= pay_last_s;
            pkt_done_r     <= pkt_done_s;
            crc_err_r      <= crc_err_s;
            sot_err_corr_r <= sot_err_corr_s;
            sot_err_r      <= sot_err_s;
            trunc_err_r    <= trunc_err_s;
            wc_err_r       <= wc_err_s;
        end
    end

    assign hdr_valid    = hdr_valid_r;
    assign hdr_di       = hdr_di_r;
    assign hdr_wc       = hdr_wc_r;
    assign ecc_err      = ecc_err_r;
    assign pay_data     = pay_data_r;
    assign pay_valid    = pay_valid_r;
    assign pay_first    = pay_first_r;
    assign pay_last     = pay_last_r;
    assign pkt_done     = pkt_done_r;
    assign crc_err      = crc_err_r;
    assign sot_err_corr = sot_err_corr_r;
    assign sot_err      = sot_err_r;
    assign trunc_err    = trunc_err_r;
    assign wc_err       = wc_err_r;

endmodule

// File: tb/tb_mipi_rx_lane_pkt.sv
// Randomized bench for mipi_rx_lane_pkt: each burst is described at packet level and
// the expected per-cycle outputs are derived from byte positions within the burst.
module tb_mipi_rx_lane_pkt;
    localparam logic [15:0] MAXWC = 16'h0100;
    localparam logic [5:0]  SDT   = 6'h0F;

    logic clk = 1'b0, rst_n = 1'b0, rx_active = 1'b0;
    logic sync = 1'b0, errsync = 1'b0, nosync = 1'b0;
    logic [7:0] hsrx_data = 8'd0;
    logic hdr_valid, ecc_err, pay_valid, pay_first, pay_last, pkt_done, crc_err;
    logic sot_err_corr, sot_err, trunc_err, wc_err;
    logic [7:0] hdr_di, pay_data;
    logic [15:0] hdr_wc;

    int total = 0, bad = 0;
    logic [7:0] pkt_q[$];
    logic [7:0] m_di;
    logic [15:0] m_wc;
    int  m_wci, m_needed;
    bit  m_short, m_wcbad;

    mipi_rx_lane_pkt #(.SHORT_DT_MAX(SDT), .CHECK_CRC(1'b1), .MAX_WC(MAXWC)) dut (
        .hs_byte_clkd(clk), .rst_n(rst_n), .rx_active(rx_active), .sync(sync),
        .errsync(errsync), .nosync(nosync), .hsrx_data(hsrx_data),
        .hdr_valid(hdr_valid), .hdr_di(hdr_di), .hdr_wc(hdr_wc), .ecc_err(ecc_err),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_first(pay_first), .pay_last(pay_last),
        .pkt_done(pkt_done), .crc_err(crc_err), .sot_err_corr(sot_err_corr), .sot_err(sot_err),
        .trunc_err(trunc_err), .wc_err(wc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [15:0] crc16(input int first, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ pkt_q[first + i][b]) c = (c >> 1) ^ 16'h8408;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    // Build a packet in pkt_q and record its packet-level properties
    task automatic mk_pkt(input logic [7:0] d, input logic [15:0] w, input bit seq,
                          input logic [7:0] ecc_x, input logic [7:0] crc_x);
        logic [15:0] c;
        pkt_q.delete();
        m_di = d; m_wc = w; m_wci = int'(w);
        m_short = (d[5:0] <= SDT);
        m_wcbad = !m_short && (w > MAXWC);
        m_needed = (m_short || m_wcbad) ? 4 : 6 + m_wci;
        pkt_q.push_back(d); pkt_q.push_back(w[7:0]); pkt_q.push_back(w[15:8]);
        pkt_q.push_back({2'b00, ecc6({w, d})} ^ ecc_x);
        if (!m_short && !m_wcbad) begin
            for (int i = 0; i < m_wci; i++) pkt_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
            c = crc16(4, m_wci);
            pkt_q.push_back(c[7:0] ^ crc_x);
            pkt_q.push_back(c[15:8]);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic n, input logic a, input logic [7:0] d);
        sync = s; errsync = e; nosync = n; rx_active = a; hsrx_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // kind: 0 SYNC, 1 ERRSYNC, 2 NOSYNC, 3 SYNC with RX_ACTIVE low; act = active byte cycles after SoT
    task automatic run_burst(input int kind, input int act);
        bit live, hv, pv, pd, te;
        logic [7:0] d;
        live = (kind == 0) || (kind == 1);
        for (int c = 0; c <= act + 3; c++) begin
            d = 8'($urandom);
            if (c >= 1 && c <= act && c <= pkt_q.size()) d = pkt_q[c - 1];
            if (c == 0) drive(kind == 0 || kind == 3, kind == 1, kind == 2, kind != 3, d);
            else        drive(1'b0, 1'b0, 1'b0, c <= act, d);
            hv = live && act >= 4 && c == 4;
            pv = live && !m_short && !m_wcbad && c >= 5 && c <= 4 + m_wci && c <= act;
            pd = live && ((m_short && hv) || (!m_short && !m_wcbad && c == 6 + m_wci && act >= c));
            te = live && act < m_needed && c == act + 1;
            chk("hdr_valid", hdr_valid, hv);
            chk("pay_valid", pay_valid, pv);
            chk("pay_first", pay_first, pv && c == 5);
            chk("pay_last", pay_last, pv && c == 4 + m_wci);
            chk("pkt_done", pkt_done, pd);
            chk("trunc_err", trunc_err, te);
            chk("wc_err", wc_err, hv && m_wcbad);
            chk("sot_err_corr", sot_err_corr, c == 0 && kind == 1);
            chk("sot_err", sot_err, c == 0 && kind == 2);
            if (hv) begin
                chk("hdr_di", hdr_di, m_di);
                chk("hdr_wc", hdr_wc, m_wc);
                chk("ecc_err", ecc_err, pkt_q[3] != {2'b00, ecc6({m_wc, m_di})});
            end
            if (pv) chk("pay_data", pay_data, pkt_q[c - 1]);
            if (pd && !m_short)
                chk("crc_err", crc_err, {pkt_q[5 + m_wci], pkt_q[4 + m_wci]} != crc16(4, m_wci));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulses"}, {hdr_valid, ecc_err, pay_valid, pay_first, pay_last, pkt_done,
                              crc_err, sot_err_corr, sot_err, trunc_err, wc_err}, 32'd0);
        chk({tag, "_hdr"}, {hdr_di, hdr_wc}, 32'd0);
        chk({tag, "_pay_data"}, pay_data, 32'd0);
    endtask

    initial begin
        int r, act;
        logic [7:0] d;
        logic [15:0] w;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        mk_pkt(8'h00, 16'h1234, 1'b0, 8'h00, 8'h00); run_burst(0, 6);
        mk_pkt(8'h2A, 16'h0004, 1'b1, 8'h00, 8'h00); run_burst(0, 11);
        mk_pkt(8'h2A, 16'h0004, 1'b1, 8'h00, 8'h01); run_burst(0, 10);
        mk_pkt(8'h2A, 16'h0004, 1'b1, 8'h01, 8'h00); run_burst(0, 10);
        mk_pkt(8'h2A, 16'h0010, 1'b0, 8'h00, 8'h00); run_burst(0, 9);
        mk_pkt(8'h01, 16'h00AA, 1'b0, 8'h00, 8'h00); run_burst(2, 6);
        run_burst(1, 6);
        run_burst(3, 6);
        mk_pkt(8'h2A, 16'h0000, 1'b0, 8'h00, 8'h00); run_burst(0, 7);
        mk_pkt(8'h2A, 16'h0200, 1'b0, 8'h00, 8'h00); run_burst(0, 8);
        mk_pkt(8'h2A, 16'h0100, 1'b0, 8'h00, 8'h00); run_burst(0, 4 + 256 + 2);

        for (int it = 0; it < 80; it++) begin
            d = 8'($urandom);
            if (d[5:0] <= SDT) w = 16'($urandom);
            else if ($urandom_range(0, 7) == 0) w = 16'($urandom_range(257, 65535));
            else w = 16'($urandom_range(0, 24));
            mk_pkt(d, w, 1'b0, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                   ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            if ($urandom_range(0, 4) == 0) act = $urandom_range(0, m_needed - 1);
            else act = m_needed + $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            run_burst((r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3, act);
        end

        // Reset in the middle of a payload: outputs clear at once, bytes afterwards are ignored
        mk_pkt(8'h2B, 16'h0008, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, pkt_q[i]);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i < 14; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, pkt_q[i]);
            chk_all_zero("post_rst");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        mk_pkt(8'h2A, 16'h0004, 1'b1, 8'h00, 8'h00); run_burst(0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
